// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: hazard FSM states, MemRead codes, opcodes,
// the hazard control bundle and the load-use match helper.
package pipeline_pkg;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_ERR      = 2'd2
  } hz_state_e;

  typedef enum logic [1:0] {
    MR_NONE = 2'd0,
    MR_LW   = 2'd1,
    MR_LH   = 2'd2,
    MR_LHU  = 2'd3
  } memread_e;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_LH    = 6'h21;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_LHU   = 6'h25;
  localparam logic [5:0] OP_SW    = 6'h2b;

  typedef struct packed {
    logic pc_we;
    logic ifid_we;
    logic idex_we;
    logic exmem_we;
    logic ifid_flush;
    logic idex_bubble;
    logic memwb_bubble;
  } hz_ctrl_t;

  localparam hz_ctrl_t CTRL_RUN    = 7'b1111_000;
  localparam hz_ctrl_t CTRL_HOLD   = 7'b0000_001;
  localparam hz_ctrl_t CTRL_BRANCH = 7'b1111_110;
  localparam hz_ctrl_t CTRL_LDUSE  = 7'b0011_010;
  localparam hz_ctrl_t CTRL_ERR    = 7'b0000_000;
  localparam hz_ctrl_t CTRL_RST    = 7'b0000_111;

  // A load in EX writes a register the ID instruction reads; $zero never hazards.
  function automatic logic load_use_hit(input memread_e mr, input logic [4:0] ex_rt,
                                        input logic [4:0] id_rs, input logic [4:0] id_rt,
                                        input logic uses_rt);
    return (mr != MR_NONE) && (ex_rt != 5'd0) &&
           ((ex_rt == id_rs) || (uses_rt && (ex_rt == id_rt)));
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter used for the hazard performance counters.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  // Count up on inc, sticking at all-ones instead of wrapping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                cnt <= '0;
    else if (inc && ~&cnt)  cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard controller for the 5-stage pipeline: memory-wait stalls with a
// timeout to a sticky error state, taken-branch flushes, load-use stalls,
// and saturating stall/flush counters.
module pipeline_hazard_ctrl
  import pipeline_pkg::*;
#(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rt,
  input  logic [1:0]       ex_memread,
  input  logic [4:0]       ex_rt,
  input  logic             ex_branch_taken,
  input  logic             mem_access,
  input  logic             mem_ready,
  output logic             pc_we,
  output logic             ifid_we,
  output logic             idex_we,
  output logic             exmem_we,
  output logic             ifid_flush,
  output logic             idex_bubble,
  output logic             memwb_bubble,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int WC_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WC_W-1:0] TO_VAL = WC_W'(MEM_TIMEOUT);

  hz_state_e       state, state_nxt;
  logic [WC_W-1:0] wait_cnt, wait_nxt;
  logic            mem_hold, load_use;
  hz_ctrl_t        ctrl;

  // mem_ready with no access in MEM is meaningless and drops out here.
  assign mem_hold = (state != ST_ERR) && mem_access && !mem_ready;
  assign load_use = load_use_hit(memread_e'(ex_memread), ex_rt, id_rs, id_rt, id_uses_rt);

  // State and consecutive-wait counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_RUN;
      wait_cnt <= '0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_nxt;
    end
  end

  // Next state: the edge that completes MEM_TIMEOUT held cycles enters ERR.
  always_comb begin
    wait_nxt  = mem_hold ? wait_cnt + 1'b1 : '0;
    state_nxt = state;
    case (state)
      ST_ERR:  state_nxt = ST_ERR;
      default: begin
        if (mem_hold) state_nxt = (wait_nxt >= TO_VAL) ? ST_ERR : ST_MEM_WAIT;
        else          state_nxt = ST_RUN;
      end
    endcase
  end

  // Mealy control decode; priority: reset, error, memory hold, branch, load-use.
  always_comb begin
    ctrl = CTRL_RUN;
    if (rst)                    ctrl = CTRL_RST;
    else if (state == ST_ERR)   ctrl = CTRL_ERR;
    else if (mem_hold)          ctrl = CTRL_HOLD;
    else if (ex_branch_taken)   ctrl = CTRL_BRANCH;
    else if (load_use)          ctrl = CTRL_LDUSE;
  end

  assign pc_we        = ctrl.pc_we;
  assign ifid_we      = ctrl.ifid_we;
  assign idex_we      = ctrl.idex_we;
  assign exmem_we     = ctrl.exmem_we;
  assign ifid_flush   = ctrl.ifid_flush;
  assign idex_bubble  = ctrl.idex_bubble;
  assign memwb_bubble = ctrl.memwb_bubble;
  assign mem_err      = (state == ST_ERR);

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk (clk),
    .rst (rst),
    .inc (!pc_we && !rst),
    .cnt (stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk (clk),
    .rst (rst),
    .inc (ifid_flush && !rst),
    .cnt (flush_cnt)
  );

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Randomized scoreboard bench for pipeline_hazard_ctrl.
module tb_pipeline_hazard_ctrl;

  localparam int TO   = 15;
  localparam int CW   = 16;
  localparam int CMAX = 65535;

  logic          clk = 1'b0;
  logic          rst;
  logic [4:0]    id_rs, id_rt, ex_rt;
  logic          id_uses_rt, ex_branch_taken, mem_access, mem_ready;
  logic [1:0]    ex_memread;
  logic          pc_we, ifid_we, idex_we, exmem_we;
  logic          ifid_flush, idex_bubble, memwb_bubble, mem_err;
  logic [CW-1:0] stall_cnt, flush_cnt;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.MEM_TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .ex_memread(ex_memread), .ex_rt(ex_rt), .ex_branch_taken(ex_branch_taken),
    .mem_access(mem_access), .mem_ready(mem_ready),
    .pc_we(pc_we), .ifid_we(ifid_we), .idex_we(idex_we), .exmem_we(exmem_we),
    .ifid_flush(ifid_flush), .idex_bubble(idex_bubble), .memwb_bubble(memwb_bubble),
    .mem_err(mem_err), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  typedef struct packed {
    logic          pc_we, ifid_we, idex_we, exmem_we;
    logic          ifid_flush, idex_bubble, memwb_bubble, mem_err;
    logic [CW-1:0] stall_cnt, flush_cnt;
  } obs_t;

  obs_t q[$];
  int   checks = 0;
  int   errors = 0;
  bit   stim_done = 0;

  // Reference model state, in plain spec terms.
  bit m_err   = 0;
  int m_wait  = 0;
  int m_stall = 0;
  int m_flush = 0;

  // Drive one cycle of inputs and push the response the spec predicts.
  task automatic cyc(input bit r, input logic [4:0] rs, input logic [4:0] rt, input bit ur,
                     input logic [1:0] mr, input logic [4:0] xrt, input bit br,
                     input bit acc, input bit rdy);
    obs_t e;
    bit   hold, lu;
    @(posedge clk); #1;
    rst = r; id_rs = rs; id_rt = rt; id_uses_rt = ur; ex_memread = mr; ex_rt = xrt;
    ex_branch_taken = br; mem_access = acc; mem_ready = rdy;
    e = '0;
    if (r) begin
      e.ifid_flush = 1; e.idex_bubble = 1; e.memwb_bubble = 1;
      m_err = 0; m_wait = 0; m_stall = 0; m_flush = 0;
    end else begin
      e.mem_err   = m_err;
      e.stall_cnt = CW'(m_stall);
      e.flush_cnt = CW'(m_flush);
      if (!m_err) begin
        hold = acc && !rdy;
        lu   = (mr != 0) && (xrt != 0) && (xrt == rs || (ur && xrt == rt));
        if (hold) e.memwb_bubble = 1;
        else if (br) begin
          {e.pc_we, e.ifid_we, e.idex_we, e.exmem_we} = 4'hF;
          e.ifid_flush = 1; e.idex_bubble = 1;
        end else if (lu) begin
          e.idex_we = 1; e.exmem_we = 1; e.idex_bubble = 1;
        end else
          {e.pc_we, e.ifid_we, e.idex_we, e.exmem_we} = 4'hF;
        m_wait = hold ? m_wait + 1 : 0;
        if (m_wait >= TO) m_err = 1;
      end
      if (!e.pc_we && m_stall < CMAX) m_stall++;
      if (e.ifid_flush && m_flush < CMAX) m_flush++;
    end
    q.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 5'd1, 5'd2, 1, 2'd0, 5'd0, 0, 0, 1);
  endtask

  // Monitor: every falling edge, compare the DUT against the oldest expectation.
  initial begin
    obs_t a, e;
    forever begin
      @(negedge clk);
      if (q.size() != 0) begin
        e = q.pop_front();
        a = '{pc_we, ifid_we, idex_we, exmem_we, ifid_flush, idex_bubble, memwb_bubble,
              mem_err, stall_cnt, flush_cnt};
        checks++;
        if (a !== e) begin
          errors++;
          if (errors <= 20)
            $display("FAIL ctrl@%0t got %h want %h (we/flush/bub/err=%b/%b cnt=%0d,%0d vs %b/%b %0d,%0d)",
                     $time, a, e, a[2*CW+7 -: 8], e[2*CW+7 -: 8], a.stall_cnt, a.flush_cnt,
                     e[2*CW+7 -: 8], e[2*CW+7 -: 8], e.stall_cnt, e.flush_cnt);
        end
      end
    end
  end

  initial begin
    rst = 1; id_rs = 0; id_rt = 0; id_uses_rt = 0; ex_memread = 0; ex_rt = 0;
    ex_branch_taken = 0; mem_access = 0; mem_ready = 0;
    // Reset state
    repeat (3) cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
    idle(2);
    // lw $8 followed by a reader of $8: one stall cycle, then free-running
    cyc(0, 5'd8, 5'd3, 1, 2'd1, 5'd8, 0, 0, 1);
    idle(2);
    // lh to $zero never stalls
    cyc(0, 5'd0, 5'd0, 1, 2'd2, 5'd0, 0, 0, 1);
    // rt match only counts when rt is read
    cyc(0, 5'd1, 5'd9, 0, 2'd3, 5'd9, 0, 0, 1);
    cyc(0, 5'd1, 5'd9, 1, 2'd3, 5'd9, 0, 0, 1);
    // Branch beats load-use
    cyc(0, 5'd8, 5'd3, 1, 2'd1, 5'd8, 1, 0, 1);
    idle(1);
    // Three memory wait cycles then ready; mem_ready without access ignored
    repeat (3) cyc(0, 5'd8, 5'd3, 1, 2'd1, 5'd8, 1, 1, 0);
    cyc(0, 5'd1, 5'd2, 1, 2'd0, 5'd0, 0, 1, 1);
    cyc(0, 5'd1, 5'd2, 1, 2'd0, 5'd0, 1, 0, 1);
    // Timeout: 15 held cycles, then sticky error; reset recovers
    repeat (TO) cyc(0, 5'd1, 5'd2, 1, 2'd0, 5'd0, 0, 1, 0);
    repeat (4) cyc(0, 5'd1, 5'd2, 1, 2'd0, 5'd0, 1, 1, 1);
    cyc(1, 0, 0, 0, 0, 0, 0, 1, 0);
    idle(2);
    // Reset in the middle of a memory wait leaves no residual hold
    repeat (6) cyc(0, 5'd1, 5'd2, 1, 2'd0, 5'd0, 0, 1, 0);
    cyc(1, 0, 0, 0, 0, 0, 0, 1, 0);
    repeat (10) cyc(0, 5'd1, 5'd2, 1, 2'd0, 5'd0, 0, 1, 0);
    idle(2);
    // Random traffic, mostly ready memory
    for (int i = 0; i < 3000; i++)
      cyc($urandom_range(99) == 0, 5'($urandom_range(7)), 5'($urandom_range(7)),
          1'($urandom), 2'($urandom), 5'($urandom_range(7)), $urandom_range(7) == 0,
          $urandom_range(3) == 0, $urandom_range(3) != 0);
    // Random traffic with slow memory so timeouts occur
    for (int i = 0; i < 3000; i++)
      cyc($urandom_range(49) == 0, 5'($urandom_range(7)), 5'($urandom_range(7)),
          1'($urandom), 2'($urandom), 5'($urandom_range(7)), $urandom_range(3) == 0,
          $urandom_range(7) != 0, $urandom_range(19) == 0);
    // Saturation: park in ERR (pc_we=0 every cycle) past 65535 stalls
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (TO) cyc(0, 5'd1, 5'd2, 1, 2'd0, 5'd0, 0, 1, 0);
    for (int i = 0; i < 65540; i++) cyc(0, 5'd1, 5'd2, 1, 2'd0, 5'd0, 0, 0, 1);
    stim_done = 1;
    repeat (3) @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d pending want 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
